fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline latch. It owns the PC and drives the instruction-memory request/done handshake. It delivers instructions to decode and to the hazard unit through the FD_* outputs. It freezes on the hazard unit's stall, squashes on branch/jump redirect from execute, and stops fetching after HALT.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INSTR, 16'h0800, encoding placed in FD_instr for bubbles and squashes
HALT_OPC, 5'b00000, opcode (instr[15:11]) that stops fetching

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
hazard_stall  in  1  NOP output of hazard unit; hold PC and FD latch
redirect_valid  in  1  taken branch/jump resolved in execute
redirect_pc  in  16  redirect target
imem_rd  out  1  fetch request
imem_addr  out  16  fetch address (= pc)
imem_data  in  16  instruction, valid only when imem_done=1
imem_done  in  1  one-cycle completion pulse, same cycle as request (hit) or later
imem_err  in  1  access fault, qualified by imem_done
FD_instr  out  16  instruction in IF/ID latch
FD_pc_inc  out  16  address of FD_instr + 2
FD_valid  out  1  FD_instr is a real instruction
FD_err  out  1  FD_instr came from a faulting fetch
halted  out  1  fetch stopped (state HALTED)

Behaviour:
- Reset (async): pc=RESET_PC, FD_instr=NOP_INSTR, FD_pc_inc=0, FD_valid=0, FD_err=0, buf_valid=0, squash=0, state=FETCH, halted=0.
- States:
  - FETCH: imem_rd = ~buf_valid; imem_addr=pc.
  - HALTED: imem_rd=0; halted=1.
- Handshake:
  - Once imem_rd rises, imem_rd and imem_addr stay constant until the imem_done cycle.
  - outstanding = imem_rd & ~imem_done.
- Accept: imem_done & ~squash & ~redirect_valid. On accept: pc <= pc+2, 16-bit wrap (FFFE -> 0000).
  - If accepted instr[15:11]==HALT_OPC or imem_err=1: state -> HALTED.
- Per-cycle priority: rst > redirect_valid > hazard_stall > normal.
- Redirect (redirect_valid=1):
  - FD_instr=NOP_INSTR, FD_valid=0, FD_err=0; buf_valid=0; state -> FETCH.
  - If no access outstanding: pc <= redirect_pc.
  - If outstanding: squash=1, pend_pc <= redirect_pc, pc unchanged.
  - A later redirect while squash=1 overwrites pend_pc.
- Squash completion: imem_done while squash=1 -> data discarded, pc <= pend_pc, squash=0, no FD or buf update.
- Stall (hazard_stall=1, no redirect):
  - FD_* hold.
  - An accept in this cycle writes buf_instr/buf_err/buf_pc_inc and sets buf_valid=1.
  - buf_valid=1 blocks further requests.
- Normal (no stall, no redirect):
  - buf_valid=1: FD <= buffer, FD_valid=1, buf_valid=0. imem_done cannot occur this cycle because no request is outstanding.
  - else accept: FD_instr=imem_data, FD_pc_inc=pc+2, FD_valid=1, FD_err=imem_err.
  - else: bubble, FD_instr=NOP_INSTR, FD_valid=0, FD_err=0.
- HALTED:
  - FD behaves as normal/stall with no new accepts; the buffer still drains.
  - pc is frozen.
  - Only redirect_valid leaves HALTED, because the HALT was on a wrong path.
- Latency: with a single-cycle hit and no stall, the instruction at pc is in FD the next edge, so throughput is 1 per cycle.

Test Plan:
- Reset, then release with 1-cycle hits returning 16'hA001, A002 at pc 0, 2 -> after 2 edges FD_instr=A002, FD_pc_inc=0004, FD_valid=1, imem_addr=0004.
- Memory takes 3 cycles per done -> imem_addr holds 0000 for 3 cycles with FD_valid=0 bubbles, then FD_instr=data, FD_pc_inc=0002.
- hazard_stall high 2 cycles while done returns 16'h4321 -> FD unchanged, buf_valid=1, imem_rd=0; after stall drops FD_instr=4321 next edge, then fetch resumes at pc+2.
- redirect_valid with redirect_pc=0040 during outstanding access to 0010, done 2 cycles later with 16'hBEEF -> BEEF never in FD, FD_valid=0, next imem_addr=0040.
- Fetch returns 16'h0000 at pc 0008 -> halted=1, imem_rd=0, pc=000A frozen; later redirect to 0020 -> halted=0, imem_addr=0020.
- imem_err=1 with done at pc FFFE -> FD_err=1, pc wraps to 0000, halted=1; assert rst mid-wait -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID latch.
// Owns the PC, runs the imem handshake, buffers fetches under stall.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter logic [4:0]  HALT_OPC  = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard_stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_done,
    input  logic        imem_err,
    output logic [15:0] FD_instr,
    output logic [15:0] FD_pc_inc,
    output logic        FD_valid,
    output logic        FD_err,
    output logic        halted
);

    typedef enum logic {
        S_FETCH,
        S_HALTED
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [15:0] pc;
    logic [15:0] pc_inc;
    logic [15:0] pend_pc;
    logic        squash;

    logic        buf_valid;
    logic [15:0] buf_instr;
    logic [15:0] buf_pc_inc;
    logic        buf_err;

    logic        outstanding;
    logic        accept;
    logic        squash_done;
    logic        stop;

    assign imem_rd     = (state == S_FETCH) & ~buf_valid;
    assign imem_addr   = pc;
    assign halted      = (state == S_HALTED);
    assign pc_inc      = pc + 16'd2;

    assign outstanding = imem_rd & ~imem_done;
    assign accept      = imem_rd & imem_done & ~squash & ~redirect_valid;
    assign squash_done = imem_rd & imem_done & squash;
    assign stop        = (imem_data[15:11] == HALT_OPC) | imem_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_FETCH: begin
                if (accept && stop) begin
                    state_next = S_HALTED;
                end
            end
            S_HALTED: begin
                state_next = S_HALTED;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
        // The halting instruction was on a wrong path.
        if (redirect_valid) begin
            state_next = S_FETCH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            pend_pc    <= RESET_PC;
            squash     <= 1'b0;
            buf_valid  <= 1'b0;
            buf_instr  <= NOP_INSTR;
            buf_pc_inc <= 16'h0000;
            buf_err    <= 1'b0;
            FD_instr   <= NOP_INSTR;
            FD_pc_inc  <= 16'h0000;
            FD_valid   <= 1'b0;
            FD_err     <= 1'b0;
        end else if (redirect_valid) begin
            FD_instr  <= NOP_INSTR;
            FD_valid  <= 1'b0;
            FD_err    <= 1'b0;
            buf_valid <= 1'b0;
            // An in-flight access must finish before the PC may move.
            if (outstanding) begin
                squash  <= 1'b1;
                pend_pc <= redirect_pc;
            end else begin
                pc     <= redirect_pc;
                squash <= 1'b0;
            end
        end else begin
            if (squash_done) begin
                pc     <= pend_pc;
                squash <= 1'b0;
            end
            if (accept) begin
                pc <= pc_inc;
            end
            if (hazard_stall) begin
                if (accept) begin
                    buf_valid  <= 1'b1;
                    buf_instr  <= imem_data;
                    buf_pc_inc <= pc_inc;
                    buf_err    <= imem_err;
                end
            end else if (buf_valid) begin
                FD_instr  <= buf_instr;
                FD_pc_inc <= buf_pc_inc;
                FD_err    <= buf_err;
                FD_valid  <= 1'b1;
                buf_valid <= 1'b0;
            end else if (accept) begin
                FD_instr  <= imem_data;
                FD_pc_inc <= pc_inc;
                FD_err    <= imem_err;
                FD_valid  <= 1'b1;
            end else begin
                FD_instr <= NOP_INSTR;
                FD_valid <= 1'b0;
                FD_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage.
// Model: the fetch stream is sequential from the last redirect target until a HALT/fault.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hazard_stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic [15:0] imem_data = 16'h0000;
    logic        imem_done = 1'b0;
    logic        imem_err = 1'b0;
    logic [15:0] FD_instr;
    logic [15:0] FD_pc_inc;
    logic        FD_valid;
    logic        FD_err;
    logic        halted;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .hazard_stall  (hazard_stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_rd       (imem_rd),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .imem_done     (imem_done),
        .imem_err      (imem_err),
        .FD_instr      (FD_instr),
        .FD_pc_inc     (FD_pc_inc),
        .FD_valid      (FD_valid),
        .FD_err        (FD_err),
        .halted        (halted)
    );

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc_inc;
        logic        err;
    } exp_t;

    exp_t        q[$];
    logic [15:0] mem[0:32767];
    logic        errm[0:32767];

    int          vectors = 0;
    int          miscompares = 0;
    bit          run = 1'b0;

    // Model state
    logic [15:0] fptr;
    int          epoch;
    bit          mhalted;
    // Memory responder state
    bit          busy;
    logic [15:0] raddr;
    int          repoch;
    int          lat;
    int          cnt;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one delivery per unstalled edge with FD_valid set.
    logic        mon_s;
    logic        mon_r;
    logic        prev_ok = 1'b0;
    logic [15:0] prev_instr;
    logic [15:0] prev_inc;
    logic        prev_valid;
    logic        prev_err;
    exp_t        e;

    always @(posedge clk) begin
        if (run && !rst) begin
            mon_s = hazard_stall;
            mon_r = redirect_valid;
            #1;
            if (mon_r) begin
                check("fd_valid_on_redirect", 32'(FD_valid), 32'd0);
            end else if (mon_s) begin
                if (prev_ok) begin
                    check("stall_hold_instr", 32'(FD_instr), 32'(prev_instr));
                    check("stall_hold_inc", 32'(FD_pc_inc), 32'(prev_inc));
                    check("stall_hold_valid", 32'(FD_valid), 32'(prev_valid));
                    check("stall_hold_err", 32'(FD_err), 32'(prev_err));
                end
            end else if (FD_valid) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_delivery: got %h expected none", FD_instr);
                end else begin
                    e = q.pop_front();
                    check("fd_instr", 32'(FD_instr), 32'(e.instr));
                    check("fd_pc_inc", 32'(FD_pc_inc), 32'(e.pc_inc));
                    check("fd_err", 32'(FD_err), 32'(e.err));
                end
            end
            prev_instr = FD_instr;
            prev_inc   = FD_pc_inc;
            prev_valid = FD_valid;
            prev_err   = FD_err;
            prev_ok    = 1'b1;
        end
    end

    // One cycle of stimulus, applied at a negedge, plus the memory model.
    task automatic cycle(input bit stall, input bit redir, input logic [15:0] target);
        logic        done;
        logic [15:0] data;
        logic        err;
        exp_t        x;
        done = 1'b0;
        data = 16'($urandom);
        err  = 1'b0;
        check("halted", 32'(halted), 32'(mhalted));
        if (mhalted) begin
            check("no_fetch_when_halted", 32'(imem_rd), 32'd0);
        end
        if (imem_rd) begin
            if (!busy) begin
                busy   = 1'b1;
                raddr  = imem_addr;
                repoch = epoch;
                lat    = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
                cnt    = 0;
            end else begin
                check("addr_stable", 32'(imem_addr), 32'(raddr));
            end
            if (cnt == lat) begin
                done = 1'b1;
                data = mem[raddr[15:1]];
                err  = errm[raddr[15:1]];
                busy = 1'b0;
                if (!redir && repoch == epoch) begin
                    check("fetch_addr", 32'(raddr), 32'(fptr));
                    x.instr  = data;
                    x.pc_inc = fptr + 16'd2;
                    x.err    = err;
                    q.push_back(x);
                    fptr = fptr + 16'd2;
                    if (data[15:11] == 5'b00000 || err) begin
                        mhalted = 1'b1;
                    end
                end
            end else begin
                cnt++;
            end
        end else if (busy) begin
            check("rd_held", 32'(imem_rd), 32'd1);
            busy = 1'b0;
        end
        if (redir) begin
            epoch++;
            fptr    = target;
            mhalted = 1'b0;
            q.delete();
        end
        hazard_stall   = stall;
        redirect_valid = redir;
        redirect_pc    = target;
        imem_done      = done;
        imem_data      = data;
        imem_err       = err;
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] tgt;
        bit          rd;
        for (int i = 0; i < 32768; i++) begin
            mem[i]  = 16'($urandom);
            errm[i] = ($urandom_range(0, 49) == 0);
        end
        mem[16'hFFFC >> 1]  = 16'hA001;
        errm[16'hFFFC >> 1] = 1'b0;
        mem[16'hFFFE >> 1]  = 16'hB002;
        errm[16'hFFFE >> 1] = 1'b1;
        mem[16'h0100 >> 1]  = 16'hC003;

        #12;
        check("rst_fd_instr", 32'(FD_instr), 32'h0800);
        check("rst_fd_pc_inc", 32'(FD_pc_inc), 32'h0000);
        check("rst_fd_valid", 32'(FD_valid), 32'd0);
        check("rst_fd_err", 32'(FD_err), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_imem_rd", 32'(imem_rd), 32'd1);
        check("rst_imem_addr", 32'(imem_addr), 32'h0000);

        @(negedge clk);
        fptr    = 16'h0000;
        epoch   = 0;
        mhalted = 1'b0;
        busy    = 1'b0;
        rst     = 1'b0;
        run     = 1'b1;

        for (int n = 0; n < 4000; n++) begin
            rd  = ($urandom_range(0, mhalted ? 9 : 39) == 0);
            tgt = ($urandom_range(0, 7) == 0) ? 16'hFFF8
                                              : {16'($urandom_range(0, 32767)), 1'b0};
            cycle($urandom_range(0, 3) == 0, rd, tgt);
        end

        // Drain, then a fetch run across the top of memory ending on a fault.
        for (int n = 0; n < 20; n++) cycle(1'b0, 1'b0, 16'h0000);
        cycle(1'b0, 1'b1, 16'hFFFC);
        for (int n = 0; n < 20; n++) cycle(1'b0, 1'b0, 16'h0000);
        check("wrap_halted", 32'(halted), 32'd1);
        check("wrap_pc", 32'(imem_addr), 32'h0000);
        check("queue_empty", 32'(q.size()), 32'd0);

        // Leave HALTED by redirect, then reset while the access is pending.
        cycle(1'b0, 1'b1, 16'h0100);
        run            = 1'b0;
        redirect_valid = 1'b0;
        imem_done      = 1'b0;
        @(negedge clk);
        check("redirect_from_halt_halted", 32'(halted), 32'd0);
        check("redirect_from_halt_addr", 32'(imem_addr), 32'h0100);
        check("redirect_from_halt_rd", 32'(imem_rd), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_fd_instr", 32'(FD_instr), 32'h0800);
        check("arst_fd_pc_inc", 32'(FD_pc_inc), 32'h0000);
        check("arst_fd_valid", 32'(FD_valid), 32'd0);
        check("arst_fd_err", 32'(FD_err), 32'd0);
        check("arst_halted", 32'(halted), 32'd0);
        check("arst_imem_addr", 32'(imem_addr), 32'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
